// File: rtl/demux2_stream.sv
// Registered 1-to-2 stream demultiplexer with a one-entry holding register per output channel.
// Optional per-channel delivered-word counters are enabled by defining DEMUX2_CNT_EN.
module demux2_stream #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    input  logic             s,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y0,
    output logic             y0_valid,
    input  logic             y0_ready,
    output logic [WIDTH-1:0] y1,
    output logic             y1_valid,
    input  logic             y1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ch_state_t;

    ch_state_t        r_st0, r_st1;
    ch_state_t        w_st0_nxt, w_st1_nxt;
    logic [WIDTH-1:0] r_y0, r_y1;
    logic             w_rdy0, w_rdy1;
    logic             w_load0, w_load1;

    // A channel can take a word when empty or when its consumer drains it this same cycle.
    assign w_rdy0   = (r_st0 == ST_EMPTY) | y0_ready;
    assign w_rdy1   = (r_st1 == ST_EMPTY) | y1_ready;
    assign in_ready = reset_n & (s ? w_rdy1 : w_rdy0);
    assign w_load0  = in_valid & in_ready & ~s;
    assign w_load1  = in_valid & in_ready & s;

    // NOTE: next-state defaults are assigned first so no path leaves a latch.
    always_comb begin
        w_st0_nxt = r_st0;
        w_st1_nxt = r_st1;
        case (r_st0)
            ST_EMPTY: if (w_load0) w_st0_nxt = ST_FULL;
            ST_FULL:  if (y0_ready && !w_load0) w_st0_nxt = ST_EMPTY;
            default:  w_st0_nxt = ST_EMPTY;
        endcase
        case (r_st1)
            ST_EMPTY: if (w_load1) w_st1_nxt = ST_FULL;
            ST_FULL:  if (y1_ready && !w_load1) w_st1_nxt = ST_EMPTY;
            default:  w_st1_nxt = ST_EMPTY;
        endcase
    end

    // NOTE: the data holding registers are reset too, because y0/y1 must read 0 during reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_st0 <= ST_EMPTY;
            r_st1 <= ST_EMPTY;
            r_y0  <= '0;
            r_y1  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            r_st0 <= w_st0_nxt;
            r_st1 <= w_st1_nxt;
            if (w_load0) r_y0 <= d;
            if (w_load1) r_y1 <= d;
        end
    end

    assign y0       = r_y0;
    assign y1       = r_y1;
    assign y0_valid = (r_st0 == ST_FULL);
    assign y1_valid = (r_st1 == ST_FULL);

`ifdef DEMUX2_CNT_EN
    logic [CNT_W-1:0] r_cnt0, r_cnt1;

    // Counters wrap freely; they count output handshakes, not loads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (y0_valid && y0_ready) r_cnt0 <= r_cnt0 + CNT_W'(1);
            if (y1_valid && y1_ready) r_cnt1 <= r_cnt1 + CNT_W'(1);
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
`else
    assign cnt0 = '0;
    assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_demux2_stream.sv
// Scoreboard bench for demux2_stream: the driver queues expected words per channel,
// a monitor pops and compares on every output handshake.
module tb_demux2_stream;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] d;
    logic        s;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] y0, y1;
    logic        y0_valid, y1_valid;
    logic        y0_ready, y1_ready;
    logic [7:0]  cnt0, cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];

`ifdef DEMUX2_CNT_EN
    localparam logic [7:0] EXP_PRE_CNT0 = 8'd16;
    localparam logic [7:0] EXP_PRE_CNT1 = 8'd7;
    localparam logic [7:0] EXP_WRAP_CNT1 = 8'h01;
`else
    localparam logic [7:0] EXP_PRE_CNT0 = 8'd0;
    localparam logic [7:0] EXP_PRE_CNT1 = 8'd0;
    localparam logic [7:0] EXP_WRAP_CNT1 = 8'h00;
`endif

    demux2_stream #(.WIDTH(32), .CNT_W(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .d        (d),
        .s        (s),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y0       (y0),
        .y0_valid (y0_valid),
        .y0_ready (y0_ready),
        .y1       (y1),
        .y1_valid (y1_valid),
        .y1_ready (y1_ready),
        .cnt0     (cnt0),
        .cnt1     (cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; exp_rdy is the hand-computed in_ready for this vector.
    task automatic step(input logic v, input logic sel, input logic [31:0] data,
                        input logic r0, input logic r1, input logic exp_rdy, input string tag);
        @(negedge clk);
        in_valid = v;
        s        = sel;
        d        = data;
        y0_ready = r0;
        y1_ready = r1;
        #1;
        check({tag, " in_ready"}, 32'(in_ready), 32'(exp_rdy));
        if (v && exp_rdy) begin
            if (sel) q1.push_back(data);
            else     q0.push_back(data);
        end
    endtask

    // Monitor: inputs settle at negedge, so negedge+2 shows exactly what the next posedge sees.
    always begin
        @(negedge clk);
        #2;
        if (reset_n) begin
            if (y0_valid && y0_ready) begin
                if (q0.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL y0 unexpected word: got %h expected none", y0);
                end else begin
                    check("y0 data", y0, q0.pop_front());
                end
            end
            if (y1_valid && y1_ready) begin
                if (q1.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL y1 unexpected word: got %h expected none", y1);
                end else begin
                    check("y1 data", y1, q1.pop_front());
                end
            end
`ifndef DEMUX2_CNT_EN
            check("cnt0 tied", 32'(cnt0), 32'd0);
            check("cnt1 tied", 32'(cnt1), 32'd0);
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b1;
        d        = '0;
        s        = 1'b0;
        in_valid = 1'b0;
        y0_ready = 1'b0;
        y1_ready = 1'b0;
        #2;
        reset_n  = 1'b0;
        in_valid = 1'b1;
        #1;
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset y0_valid", 32'(y0_valid), 32'd0);
        check("reset y1_valid", 32'(y1_valid), 32'd0);
        check("reset y0", y0, 32'd0);
        check("reset y1", y1, 32'd0);
        check("reset cnt0", 32'(cnt0), 32'd0);
        check("reset cnt1", 32'(cnt1), 32'd0);
        repeat (2) @(negedge clk);
        reset_n  = 1'b1;
        in_valid = 1'b0;

        // Route to y0, then to y1
        step(1'b1, 1'b0, 32'h1234abcd, 1'b0, 1'b0, 1'b1, "route0");
        @(posedge clk); #1;
        check("route0 y0", y0, 32'h1234abcd);
        check("route0 y0_valid", 32'(y0_valid), 32'd1);
        check("route0 y1_valid", 32'(y1_valid), 32'd0);
        step(1'b1, 1'b1, 32'habcd1234, 1'b0, 1'b0, 1'b1, "route1");
        @(posedge clk); #1;
        check("route1 y1", y1, 32'habcd1234);
        check("route1 y1_valid", 32'(y1_valid), 32'd1);
        check("route1 y0 held", y0, 32'h1234abcd);

        // Backpressure on y0, then redirect to y1 while y1 drains
        step(1'b1, 1'b0, 32'hdead0001, 1'b0, 1'b0, 1'b0, "bp0");
        @(posedge clk); #1;
        check("bp0 y0 stable", y0, 32'h1234abcd);
        check("bp0 y0_valid", 32'(y0_valid), 32'd1);
        step(1'b1, 1'b1, 32'hbeef0002, 1'b0, 1'b1, 1'b1, "bp1");
        @(posedge clk); #1;
        check("bp1 y1", y1, 32'hbeef0002);
        check("bp1 y0 stable", y0, 32'h1234abcd);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, "drain_a");

        // Streaming on y0 with no bubbles
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 32'(i), 1'b1, 1'b0, 1'b1, "stream");
            @(posedge clk); #1;
            check("stream y0", y0, 32'(i));
            check("stream y0_valid", 32'(y0_valid), 32'd1);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, "drain_b");

        // Alternation: s toggles every cycle with both consumers ready
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'(i % 2), 32'h100 + 32'(i), 1'b1, 1'b1, 1'b1, "alt");
        end
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, "drain_c");
        @(posedge clk); #1;
        check("pre-reset cnt0", 32'(cnt0), 32'(EXP_PRE_CNT0));
        check("pre-reset cnt1", 32'(cnt1), 32'(EXP_PRE_CNT1));

        // Reset asserted mid-cycle with y0 holding an undelivered word
        step(1'b1, 1'b0, 32'hcafe0003, 1'b0, 1'b0, 1'b1, "pre_rst");
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        q0.delete();
        check("midrst y0_valid", 32'(y0_valid), 32'd0);
        check("midrst y1_valid", 32'(y1_valid), 32'd0);
        check("midrst y0", y0, 32'd0);
        check("midrst cnt0", 32'(cnt0), 32'd0);
        check("midrst cnt1", 32'(cnt1), 32'd0);
        check("midrst in_ready", 32'(in_ready), 32'd0);
        @(negedge clk); #1;
        check("midrst in_ready hold", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("post-rst y0_valid", 32'(y0_valid), 32'd0);

        // 257 words on y1 exercise the counter wrap
        for (int i = 0; i < 257; i++) begin
            step(1'b1, 1'b1, 32'h5000 + 32'(i), 1'b0, 1'b1, 1'b1, "wrap");
        end
        step(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1, "drain_d");
        @(posedge clk); #1;
        check("wrap cnt1", 32'(cnt1), 32'(EXP_WRAP_CNT1));
        check("wrap cnt0", 32'(cnt0), 32'd0);

        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, "final");
        @(posedge clk); #1;
        check("final y0_valid", 32'(y0_valid), 32'd0);
        check("final y1_valid", 32'(y1_valid), 32'd0);
        check("q0 drained", 32'(q0.size()), 32'd0);
        check("q1 drained", 32'(q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
